// File: rtl/fa_chk_pkg.sv
// Shared types and constants for the full-adder response checker.
package fa_chk_pkg;

  // Checker run state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fa_state_t;

  localparam int FA_NUM_VECTORS = 8;
  localparam logic [FA_NUM_VECTORS-1:0] FA_COV_FULL = 8'hFF;

  // One-hot coverage bit for an input vector {a,b,c}.
  function automatic logic [FA_NUM_VECTORS-1:0] fa_vec_bit(input logic [2:0] vec);
    logic [FA_NUM_VECTORS-1:0] one;
    one = 8'd1;
    return one << vec;
  endfunction

endpackage

// File: rtl/full_add_ref.sv
// Combinational golden model of a one-bit full adder.
module full_add_ref (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic exp_sum,
  output logic exp_carry
);

  assign exp_sum   = a ^ b ^ c;
  assign exp_carry = (a & b) | (b & c) | (a & c);

endmodule

// File: rtl/full_add_checker.sv
// Response checker for the one-bit full adder: compares sampled DUT outputs
// against a golden model, tracks vector coverage, counts mismatches and
// records the first failing vector. Optional watchdog: FA_CHK_TIMEOUT_EN.
//
// Sample handshake: in_valid marks a settled sample; there is no ready,
// every in_valid cycle in RUN is consumed on the rising edge of clk.
module full_add_checker
  import fa_chk_pkg::*;
#(
  parameter int ERR_W          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             in_c,
  input  logic             in_sum,
  input  logic             in_carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       cov_mask,
  output logic             fail_valid,
  output logic [2:0]       fail_vec
);

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  fa_state_t                   state_q, state_d;
  logic [ERR_W-1:0]            err_q, err_d;
  logic [FA_NUM_VECTORS-1:0]   cov_q, cov_d;
  logic                        fv_q, fv_d;
  logic [2:0]                  fvec_q, fvec_d;
  logic                        busy_q, done_q, pass_q;
  logic                        to_d;
  logic [2:0]                  vec;
  logic                        exp_sum, exp_carry, mism;

  assign vec  = {in_a, in_b, in_c};
  assign mism = (in_sum != exp_sum) || (in_carry != exp_carry);

  full_add_ref u_ref (
    .a         (in_a),
    .b         (in_b),
    .c         (in_c),
    .exp_sum   (exp_sum),
    .exp_carry (exp_carry)
  );

`ifdef FA_CHK_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            to_q;
  assign timeout = to_q;
`else
  // No watchdog is built; TIMEOUT_CYCLES has no effect in this build.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
  assign timeout = 1'b0;
`endif

  // Next-state and result-register update.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cov_d   = cov_q;
    fv_d    = fv_q;
    fvec_d  = fvec_q;
    to_d    = 1'b0;
`ifdef FA_CHK_TIMEOUT_EN
    wd_d    = wd_q;
    to_d    = to_q;
`endif
    if (start) begin
      // Start from any state (re)begins a run; a same-cycle sample is dropped.
      state_d = RUN;
      err_d   = '0;
      cov_d   = '0;
      fv_d    = 1'b0;
      fvec_d  = '0;
      to_d    = 1'b0;
`ifdef FA_CHK_TIMEOUT_EN
      wd_d    = '0;
`endif
    end else if (state_q == RUN) begin
      if (in_valid) begin
        cov_d = cov_q | fa_vec_bit(vec);
        if (mism) begin
          if (err_q != ERR_MAX) err_d = err_q + 1'b1;
          if (!fv_q) begin
            fv_d   = 1'b1;
            fvec_d = vec;
          end
        end
      end
      // Coverage completion takes priority over the watchdog.
      if (cov_d == FA_COV_FULL) begin
        state_d = DONE;
      end
`ifdef FA_CHK_TIMEOUT_EN
      else if (wd_q == WD_LAST) begin
        state_d = DONE;
        to_d    = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
`endif
    end
  end

  // State and result registers; status outputs are registered from next values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      err_q   <= '0;
      cov_q   <= '0;
      fv_q    <= 1'b0;
      fvec_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef FA_CHK_TIMEOUT_EN
      wd_q    <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cov_q   <= cov_d;
      fv_q    <= fv_d;
      fvec_q  <= fvec_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
      pass_q  <= (state_d == DONE) && (err_d == '0) && (cov_d == FA_COV_FULL) && !to_d;
`ifdef FA_CHK_TIMEOUT_EN
      wd_q    <= wd_d;
      to_q    <= to_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign cov_mask   = cov_q;
  assign fail_valid = fv_q;
  assign fail_vec   = fvec_q;

endmodule

// File: doc/full_add_checker.md
# full_add_checker

Synthesizable response checker for the one-bit full adder `fullAdd`. It pairs with the stimulus side of the full-adder sanity check. It samples each applied input vector (a, b, c) together with the DUT's sum and carry, compares them against a golden model, and tracks which of the 8 input combinations have been exercised. It counts mismatches, records the first failing vector, and raises a single pass/fail verdict for on-board LEDs or a host readout.

## Interface
- `ERR_W`, default 8: width of the mismatch counter; the counter saturates at 2^ERR_W−1.
- `TIMEOUT_CYCLES`, default 1024: clock cycles allowed in RUN before the watchdog ends the run. Used only when `FA_CHK_TIMEOUT_EN` is defined.
- `clk`, input, 1: single clock; every flop is on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `start`, input, 1: one-cycle pulse that begins (or restarts) a check run.
- `in_valid`, input, 1: the current `in_*` values form one settled sample.
- `in_a`, `in_b`, `in_c`, input, 1 each: the vector applied to the DUT.
- `in_sum`, `in_carry`, input, 1 each: the DUT outputs for that vector.
- `busy`, output, 1: high while in RUN.
- `done`, output, 1: high while in DONE.
- `pass`, output, 1: verdict, meaningful only while `done` is high.
- `timeout`, output, 1: the run ended on the watchdog rather than on full coverage.
- `err_count`, output, ERR_W: saturating count of mismatched samples.
- `cov_mask`, output, 8: bit {a,b,c} is set once that vector has been sampled.
- `fail_valid`, output, 1: at least one mismatch has been seen.
- `fail_vec`, output, 3: {a,b,c} of the first mismatch.

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset (async, `rst_n`=0): state IDLE; all outputs and counters are 0.
- IDLE → RUN on `start`. Entering RUN clears `err_count`, `cov_mask`, `fail_valid`, `fail_vec`, `timeout` and the watchdog counter.
- In RUN, each `in_valid` cycle:
  - Expected sum = a^b^c; expected carry = (a&b)|(b&c)|(a&c).
  - Set `cov_mask[{a,b,c}]`.
  - On a mismatch in either sum or carry: increment `err_count`, saturating.
  - On the first mismatch only: latch `fail_vec` and set `fail_valid`.
  - Repeated samples of the same vector are each checked and counted.
- RUN → DONE when the updated `cov_mask` equals 8'hFF. The completing sample is included in the counts.
- RUN → DONE on watchdog expiry, with `timeout`=1. If coverage completes in the same cycle, coverage wins and `timeout` stays 0.
- DONE holds every result until `start` (→ RUN, cleared as above) or reset.
- `pass` = `done` & (`err_count`==0) & (`cov_mask`==8'hFF) & !`timeout`.
- `in_valid` in IDLE or DONE is ignored.
- `start` while in RUN restarts the run: counters are cleared and any `in_valid` in that cycle is ignored.

## Timing
- All outputs are registered. Results reflect a sample one cycle after its `in_valid` edge.
- `done` rises in the cycle after the completing sample.
- There is no backpressure: the checker accepts a sample every cycle. The DUT settle delay belongs to the stimulus side, which asserts `in_valid` only once inputs and outputs are stable.
- Watchdog: counts cycles spent in RUN. At count TIMEOUT_CYCLES−1 it forces DONE on the next edge.
- Reset mid-run aborts immediately. No result survives reset.

## Configuration
- `FA_CHK_TIMEOUT_EN` defined: the watchdog and `timeout` output are active as described above.
- `FA_CHK_TIMEOUT_EN` undefined: no watchdog counter is built, `timeout` is tied to 0, and RUN exits only on full coverage or reset.

## Structure
- Package `fa_chk_pkg` holds:
  - the state type (IDLE/RUN/DONE);
  - `FA_NUM_VECTORS`=8;
  - `FA_COV_FULL`=8'hFF.
- Sub-module `full_add_ref`: purely combinational golden model, (a,b,c) → (exp_sum, exp_carry). It is instantiated once.
- The top level holds the FSM, coverage register, error counter, first-fail latch and watchdog.

## Test plan
- Full coverage with a correct DUT: `start`, then 8 distinct correct samples 000..111 → `done`=1 one cycle after the 8th sample, `pass`=1, `err_count`=0, `cov_mask`=8'hFF.
- Faulted sample: same sequence, but vector 011 reports sum=1 → `pass`=0, `err_count`=1, `fail_valid`=1, `fail_vec`=3'b011.
- Partial coverage with the macro on and TIMEOUT_CYCLES=16: only vectors 000, 001, 011, 111 supplied → DONE after 16 RUN cycles, `timeout`=1, `cov_mask`=8'h8B, `pass`=0.
- Saturation with ERR_W=2: 5 faulty samples of vector 001 followed by the remaining correct vectors → `err_count`=3 and `fail_vec`=3'b001.
- Restart and reset: `start` pulsed mid-run after 3 samples → `cov_mask`=0 the next cycle. `rst_n` low during RUN → all outputs 0 immediately, independent of `clk`.
- Ignored input: `in_valid` pulses while in IDLE or DONE → no output changes.
